pwm_dac: RTL and testbench
==========================

PWM_DAC -- requirements
Module: pwm_dac

Interface
REQ-001 SHALL have parameter: PRESCALE, default 1, clocks per PWM counter step; legal range 1..1023.
REQ-002 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-003 SHALL have port: nRst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: enable  input  1  block run enable; low = synchronous idle/clear.
REQ-005 SHALL have port: sample  input  8  unsigned audio sample from oscillator chain.
REQ-006 SHALL have port: sample_valid  input  1  sample presented this cycle.
REQ-007 SHALL have port: sample_ready  output  1  holding register can accept a sample.
REQ-008 SHALL have port: pwm_out  output  1  registered PWM audio bit.
REQ-009 SHALL have port: period_start  output  1  one-cycle pulse at each PWM period boundary.
REQ-010 SHALL have port: underrun  output  1  one-cycle pulse when a period boundary finds the holding register empty.
REQ-011 SHALL have port: underrun_sticky  output  1  latched underrun flag.

Function
REQ-012 SHALL keep prescale counter pre_cnt (10 bit), counting 0..PRESCALE-1, wrapping to 0; tick = enable && pre_cnt == PRESCALE-1.
REQ-013 SHALL keep 8-bit pwm_cnt, incremented on tick only, 255 -> 0 wrap; pre_cnt held at 0 and tick high every enabled cycle when PRESCALE=1.
REQ-014 SHALL keep one-entry holding register hold[7:0] with flag hold_full.
REQ-015 SHALL drive sample_ready = enable && !hold_full, purely from registered state (no combinational path from sample_valid).
REQ-016 SHALL accept a sample (hold <= sample, hold_full <= 1) on a cycle with sample_valid && sample_ready; sample ignored otherwise.
REQ-017 SHALL define boundary = tick && pwm_cnt == 255.
REQ-018 On boundary with hold_full=1: duty <= hold, hold_full <= 0, period_start pulse next cycle.
REQ-019 On boundary with hold_full=0: duty unchanged, period_start pulse, underrun pulse, underrun_sticky <= 1.
REQ-020 Simultaneous accept and boundary with hold empty SHALL count as underrun; accepted sample lands in hold and loads at the following boundary.
REQ-021 SHALL register pwm_out <= enable && (pwm_cnt < duty), one-clock latency from counter state.
REQ-022 duty=0 SHALL give pwm_out constantly 0; duty=255 SHALL give 255 high steps of 256; high time per period = duty x PRESCALE clocks.
REQ-023 period_start and underrun SHALL be registered, high exactly one clock per boundary.
REQ-024 enable low SHALL synchronously clear pre_cnt, pwm_cnt, hold_full, duty, pwm_out, period_start, underrun, underrun_sticky; hold contents don't-care.
REQ-025 enable rising SHALL start with pwm_cnt=0, first boundary after 256xPRESCALE enabled clocks.
REQ-026 underrun_sticky SHALL clear only via reset or enable low.

Reset
REQ-027 nRst high SHALL asynchronously force pre_cnt=0, pwm_cnt=0, hold=0, hold_full=0, duty=0, pwm_out=0, period_start=0, underrun=0, underrun_sticky=0; sample_ready=0 while enable low.
REQ-028 Reset asserted mid-period SHALL discard held and active samples; operation restarts per REQ-025 after release.

Verification
REQ-029 PRESCALE=1, enable=1, sample=0x40 valid at cycle 1 -> sample_ready falls next clock; at first boundary (cycle 256) duty=0x40, period_start pulses; next period pwm_out high 64 clocks, low 192.
REQ-030 PRESCALE=4, duty loaded 0x80 -> period 1024 clocks, pwm_out high 512 clocks, period_start every 1024 clocks.
REQ-031 No sample supplied across a boundary -> underrun pulse 1 clock, underrun_sticky=1, prior duty waveform repeats unchanged.
REQ-032 sample_valid held high with hold_full=1 -> no acceptance; new value taken only after boundary frees hold (sample_ready high again).
REQ-033 Samples 0x00 then 0xFF -> period of constant 0, then period with 255 high / 1 low clocks (PRESCALE=1).
REQ-034 nRst pulsed mid-period with duty=0x80 and hold_full=1 -> all outputs 0 immediately; after release, underrun on first boundary if no sample sent.

Source files
------------

// File: rtl/pwm_dac_if.sv
// Sample handshake between the oscillator chain (master) and the PWM DAC (slave).
interface pwm_dac_if;
  localparam int unsigned SAMPLE_W = 8;

  logic [SAMPLE_W-1:0] sample;
  logic                sample_valid;
  logic                sample_ready;

  modport master (output sample, output sample_valid, input sample_ready);
  modport slave  (input sample, input sample_valid, output sample_ready);
endinterface

// File: rtl/pwm_dac.sv
// PWM audio DAC: one-entry sample holding register feeding a duty register that
// is reloaded at every 256-step PWM period boundary; the step rate is clk/PRESCALE.
module pwm_dac #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic      clk,
  input  logic      nRst,
  input  logic      enable,
  pwm_dac_if.slave  bus,
  output logic      pwm_out,
  output logic      period_start,
  output logic      underrun,
  output logic      underrun_sticky
);

  localparam int unsigned PRE_W = 10;
  localparam int unsigned CNT_W = 8;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_out_q, pwm_out_d;
  logic             period_start_q, period_start_d;
  logic             underrun_q, underrun_d;
  logic             sticky_q, sticky_d;

  logic             tick;
  logic             boundary;
  logic             accept;
  logic             sample_ready_c;

  // Ready depends only on enable and the registered holding flag.
  assign sample_ready_c   = enable && !hold_full_q;
  assign bus.sample_ready = sample_ready_c;

  assign pwm_out         = pwm_out_q;
  assign period_start    = period_start_q;
  assign underrun        = underrun_q;
  assign underrun_sticky = sticky_q;

  // Next-state: prescaler, PWM counter, holding register, duty reload and status pulses.
  always_comb begin
    tick     = enable && (pre_cnt_q == PRE_W'(PRESCALE - 1));
    boundary = tick && (pwm_cnt_q == {CNT_W{1'b1}});
    accept   = bus.sample_valid && sample_ready_c;

    pre_cnt_d      = pre_cnt_q;
    pwm_cnt_d      = pwm_cnt_q;
    hold_d         = hold_q;
    hold_full_d    = hold_full_q;
    duty_d         = duty_q;
    pwm_out_d      = 1'b0;
    period_start_d = 1'b0;
    underrun_d     = 1'b0;
    sticky_d       = sticky_q;

    if (!enable) begin
      pre_cnt_d   = '0;
      pwm_cnt_d   = '0;
      hold_full_d = 1'b0;
      duty_d      = '0;
      sticky_d    = 1'b0;
    end else begin
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
      if (tick) begin
        pwm_cnt_d = pwm_cnt_q + CNT_W'(1);
      end
      // Accept only when empty, so an accept never coincides with a load.
      if (accept) begin
        hold_d      = bus.sample;
        hold_full_d = 1'b1;
      end
      if (boundary) begin
        period_start_d = 1'b1;
        if (hold_full_q) begin
          duty_d      = hold_q;
          hold_full_d = 1'b0;
        end else begin
          underrun_d = 1'b1;
          sticky_d   = 1'b1;
        end
      end
      pwm_out_d = pwm_cnt_q < duty_q;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      hold_q         <= '0;
      hold_full_q    <= 1'b0;
      duty_q         <= '0;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
      sticky_q       <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      hold_q         <= hold_d;
      hold_full_q    <= hold_full_d;
      duty_q         <= duty_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
      sticky_q       <= sticky_d;
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: a PRESCALE=1 instance checked per period against a
// scoreboard of expected boundary outcomes, plus a PRESCALE=4 instance.
module tb_pwm_dac;

  localparam int unsigned PRE_A  = 1;
  localparam int unsigned PRE_B  = 4;
  localparam int unsigned N_REC  = 6;
  localparam int unsigned BUDGET = 2000;

  typedef struct {
    logic ur;
    logic sticky;
    int   high;
  } exp_t;

  logic clk  = 1'b0;
  logic nRst = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic pwm_a, ps_a, ur_a, urs_a;
  logic pwm_b, ps_b, ur_b, urs_b;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_a[$];
  logic mon_go   = 1'b0;
  logic mon_done = 1'b0;
  logic [7:0] duty_m = 8'h00;
  logic       sticky_m = 1'b0;

  pwm_dac_if bus_a ();
  pwm_dac_if bus_b ();

  always #5 clk = ~clk;

  pwm_dac #(.PRESCALE(PRE_A)) dut_a (
    .clk(clk), .nRst(nRst), .enable(en_a), .bus(bus_a),
    .pwm_out(pwm_a), .period_start(ps_a), .underrun(ur_a), .underrun_sticky(urs_a)
  );

  pwm_dac #(.PRESCALE(PRE_B)) dut_b (
    .clk(clk), .nRst(nRst), .enable(en_b), .bus(bus_b),
    .pwm_out(pwm_b), .period_start(ps_b), .underrun(ur_b), .underrun_sticky(urs_b)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic wait_ps_a(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ps_a && cyc < BUDGET);
  endtask

  task automatic wait_ps_b(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ps_b && cyc < BUDGET);
  endtask

  // Present one sample on the A bus for one cycle; the hold is known empty.
  task automatic send_a(input logic [7:0] v);
    sb_a.push_back('{1'b0, sticky_m, int'(v)});
    duty_m = v;
    bus_a.sample       = v;
    bus_a.sample_valid = 1'b1;
    @(negedge clk);
    check_eq($sformatf("ready_drop_%02x", v), bus_a.sample_ready, 0);
    bus_a.sample_valid = 1'b0;
  endtask

  // Let a period pass with no sample: the next boundary must underrun.
  task automatic skip_a();
    sticky_m = 1'b1;
    sb_a.push_back('{1'b1, 1'b1, int'(duty_m)});
  endtask

  // Monitor A: at each period_start pop the expected boundary outcome, then
  // measure the high time of the period that follows.
  initial begin : mon_a
    exp_t e;
    int   cyc;
    int   hi;
    wait (mon_go);
    wait_ps_a(cyc);
    check_eq("first_boundary_cycles", cyc, 256 * PRE_A);
    for (int i = 0; i < N_REC; i++) begin
      if (sb_a.size() == 0) begin
        check_eq("scoreboard_depth", sb_a.size(), 1);
        break;
      end
      e = sb_a.pop_front();
      check_eq($sformatf("underrun_b%0d", i + 1), ur_a, e.ur);
      check_eq($sformatf("sticky_b%0d", i + 1), urs_a, e.sticky);
      hi  = 0;
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (cyc == 1) begin
          check_eq($sformatf("ps_pulse_b%0d", i + 1), ps_a, 0);
          check_eq($sformatf("ur_pulse_b%0d", i + 1), ur_a, 0);
        end
        if (pwm_a) hi++;
      end while (!ps_a && cyc < BUDGET);
      check_eq($sformatf("period_len_b%0d", i + 1), cyc, 256 * PRE_A);
      check_eq($sformatf("high_b%0d", i + 1), hi, e.high * PRE_A);
    end
    mon_done = 1'b1;
  end

  task automatic seq_a();
    int cyc;
    en_a   = 1'b1;
    mon_go = 1'b1;
    @(negedge clk);
    check_eq("ready_idle", bus_a.sample_ready, 1);
    send_a(8'h40);
    // Keep a second sample pending while the hold is full.
    bus_a.sample       = 8'h11;
    bus_a.sample_valid = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("ready_full", bus_a.sample_ready, 0);
    wait_ps_a(cyc);
    check_eq("ready_freed", bus_a.sample_ready, 1);
    sb_a.push_back('{1'b0, sticky_m, 32'h11});
    duty_m = 8'h11;
    @(negedge clk);
    check_eq("pending_taken", bus_a.sample_ready, 0);
    bus_a.sample_valid = 1'b0;
    wait_ps_a(cyc);
    skip_a();
    wait_ps_a(cyc);
    send_a(8'h00);
    wait_ps_a(cyc);
    send_a(8'hFF);
    wait_ps_a(cyc);
    send_a(8'h80);
    cyc = 0;
    while (!mon_done && cyc < 3 * BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("monitor_done", mon_done, 1);
  endtask

  task automatic seq_b();
    int cyc;
    int hi;
    en_b = 1'b1;
    @(negedge clk);
    bus_b.sample       = 8'h80;
    bus_b.sample_valid = 1'b1;
    @(negedge clk);
    bus_b.sample_valid = 1'b0;
    wait_ps_b(cyc);
    check_eq("b_first_boundary_cycles", cyc + 2, 256 * PRE_B);
    check_eq("b_underrun", ur_b, 0);
    bus_b.sample_valid = 1'b1;
    hi  = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      bus_b.sample_valid = 1'b0;
      cyc++;
      if (pwm_b) hi++;
    end while (!ps_b && cyc < BUDGET);
    check_eq("b_period_len", cyc, 256 * PRE_B);
    check_eq("b_high", hi, 128 * PRE_B);
    check_eq("b_underrun_2", ur_b, 0);
  endtask

  initial begin : main
    int cyc;
    int hi;
    bus_a.sample       = 8'h00;
    bus_a.sample_valid = 1'b0;
    bus_b.sample       = 8'h00;
    bus_b.sample_valid = 1'b0;
    #1 nRst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_pwm", pwm_a, 0);
    check_eq("rst_ps", ps_a, 0);
    check_eq("rst_ur", ur_a, 0);
    check_eq("rst_sticky", urs_a, 0);
    check_eq("rst_ready", bus_a.sample_ready, 0);
    nRst = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", bus_a.sample_ready, 0);
    check_eq("idle_pwm", pwm_a, 0);

    fork
      seq_a();
      seq_b();
    join

    // Load a full hold behind an active 0x80 duty, then reset mid-period.
    send_a(8'h80);
    repeat (40) @(negedge clk);
    check_eq("pre_reset_pwm", pwm_a, 1);
    check_eq("pre_reset_sticky", urs_a, 1);
    #2 nRst = 1'b1;
    #1;
    check_eq("async_rst_pwm", pwm_a, 0);
    check_eq("async_rst_ps", ps_a, 0);
    check_eq("async_rst_ur", ur_a, 0);
    check_eq("async_rst_sticky", urs_a, 0);
    check_eq("async_rst_pwm_b", pwm_b, 0);
    @(negedge clk);
    nRst = 1'b0;
    wait_ps_a(cyc);
    check_eq("post_rst_boundary_cycles", cyc, 256 * PRE_A);
    check_eq("post_rst_underrun", ur_a, 1);
    check_eq("post_rst_sticky", urs_a, 1);
    hi  = 0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (pwm_a) hi++;
    end while (!ps_a && cyc < BUDGET);
    check_eq("post_rst_high", hi, 0);

    // Dropping enable clears the sticky flag and ready.
    en_a = 1'b0;
    @(negedge clk);
    check_eq("disable_sticky", urs_a, 0);
    check_eq("disable_ready", bus_a.sample_ready, 0);
    check_eq("disable_pwm", pwm_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
